// File: rtl/vram_line_fetcher.sv
// vram_line_fetcher: streams one display line out of the shared video RAM's
// port B into a ping-pong line buffer and hands bytes to the pixel shifter.
// The back bank is filled while the front bank is being displayed. A
// line_start pulse promotes a completed back bank to the front. The same
// pulse also starts fetching the next line.
module vram_line_fetcher #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int LINE_BYTES = 32
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_addr,
  output logic [ADDR_W-1:0] ram_ad_b,
  output logic              ram_we_b,
  output logic [DATA_W-1:0] ram_d_b,
  input  logic [DATA_W-1:0] ram_q_b,
  input  logic              px_req,
  output logic [DATA_W-1:0] px_data,
  output logic              px_valid,
  output logic              busy,
  output logic              line_ready,
  output logic              late
);

  localparam int IDX_W = $clog2(LINE_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_BYTES - 1);
  localparam logic [IDX_W:0]   RD_END   = (IDX_W + 1)'(LINE_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_t;

  state_t state, state_nx;
  logic   fetching, draining;

  logic              front;        // bank currently served to the pixel shifter
  logic [1:0]        bank_valid;
  logic              back_done;    // back bank holds a complete line
  logic [IDX_W:0]    rd_idx;       // saturates at LINE_BYTES
  logic [IDX_W-1:0]  fetch_idx;    // k: offset of the address on ram_ad_b
  logic              wr_en_q;      // ram_q_b carries a byte for the back bank
  logic [IDX_W-1:0]  wr_idx_q;

  logic [DATA_W-1:0] line_buf [2*LINE_BYTES];

  // The read port always looks at the bank that is front after this edge's swap.
  logic           swap;
  logic           front_nx;
  logic           front_valid_nx;
  logic [IDX_W:0] rd_base;
  logic           rd_ok;

  assign ram_we_b = 1'b0;
  assign ram_d_b  = '0;
  assign busy     = fetching | draining;

  assign swap           = line_start & back_done;
  assign front_nx       = front ^ swap;
  assign front_valid_nx = swap | bank_valid[front];
  assign rd_base        = line_start ? '0 : rd_idx;
  assign rd_ok          = px_req & front_valid_nx & (rd_base < RD_END);

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    // NOTE: sequential state is assigned with <= so every register samples the
    // pre-edge values, regardless of the order of the statements.
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state: a line_start in any state (re)starts the fetch at k=0.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_nx unassigned
    // and no latch is inferred.
    state_nx = state;
    case (state)
      ST_IDLE:  if (line_start) state_nx = ST_FETCH;
      ST_FETCH: if (line_start)                 state_nx = ST_FETCH;
                else if (fetch_idx == LAST_IDX) state_nx = ST_DRAIN;
      ST_DRAIN: state_nx = line_start ? ST_FETCH : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State decode.
  always_comb begin
    fetching = 1'b0;
    draining = 1'b0;
    case (state)
      ST_FETCH: fetching = 1'b1;
      ST_DRAIN: draining = 1'b1;
      default:  ;
    endcase
  end

  // Fetch side: address stepping, write pipeline, bank swap and status pulses.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ram_ad_b   <= '0;
      fetch_idx  <= '0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      front      <= 1'b0;
      bank_valid <= '0;
      back_done  <= 1'b0;
      line_ready <= 1'b0;
      late       <= 1'b0;
    end else begin
      late       <= line_start & busy;
      // An abort during DRAIN discards the nearly-complete line.
      line_ready <= draining & ~line_start;
      wr_en_q    <= fetching & ~line_start;
      wr_idx_q   <= fetch_idx;

      if (line_start) begin
        ram_ad_b  <= line_addr;
        fetch_idx <= '0;
      end else if (fetching && fetch_idx != LAST_IDX) begin
        ram_ad_b  <= ram_ad_b + ADDR_W'(1);   // wraps through 0
        fetch_idx <= fetch_idx + IDX_W'(1);
      end

      if (line_start)    back_done <= 1'b0;
      else if (draining) back_done <= 1'b1;

      if (swap) begin
        front              <= ~front;
        bank_valid[~front] <= 1'b1;
      end
    end
  end

  // Line buffer write; the back bank is always the one not being displayed.
  always_ff @(posedge clk_sys) begin
    // NOTE: the buffer array has no reset; bank_valid guards against stale data.
    if (wr_en_q) line_buf[{~front, wr_idx_q}] <= ram_q_b;
  end

  // Read side: one byte per accepted request, returned the next cycle.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_idx   <= '0;
      px_valid <= 1'b0;
      px_data  <= '0;
    end else begin
      px_valid <= rd_ok;
      px_data  <= rd_ok ? line_buf[{front_nx, rd_base[IDX_W-1:0]}] : '0;
      rd_idx   <= rd_ok ? rd_base + (IDX_W + 1)'(1) : rd_base;
    end
  end

endmodule

// File: tb/tb_vram_line_fetcher.sv
// Bench for vram_line_fetcher: directed line fetches from a table, hand-written
// abort / reset / same-cycle sequences, and a random phase. A line-level
// reference model checks every output on every cycle.
module tb_vram_line_fetcher;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int LB     = 32;
  localparam int MASK   = (1 << ADDR_W) - 1;

  logic              clk_sys;
  logic              reset;
  logic              line_start;
  logic [ADDR_W-1:0] line_addr;
  logic [ADDR_W-1:0] ram_ad_b;
  logic              ram_we_b;
  logic [DATA_W-1:0] ram_d_b;
  logic [DATA_W-1:0] ram_q_b;
  logic              px_req;
  logic [DATA_W-1:0] px_data;
  logic              px_valid;
  logic              busy;
  logic              line_ready;
  logic              late;

  vram_line_fetcher #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BYTES(LB)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .line_start (line_start),
    .line_addr  (line_addr),
    .ram_ad_b   (ram_ad_b),
    .ram_we_b   (ram_we_b),
    .ram_d_b    (ram_d_b),
    .ram_q_b    (ram_q_b),
    .px_req     (px_req),
    .px_data    (px_data),
    .px_valid   (px_valid),
    .busy       (busy),
    .line_ready (line_ready),
    .late       (late)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Video RAM port B: registered read.
  logic [7:0] mem [1 << ADDR_W];
  always @(posedge clk_sys) ram_q_b <= mem[ram_ad_b];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (line level) ----------------
  // A fetch is a countdown of busy cycles; its line content is taken from
  // the RAM at line_start and becomes the back line when the countdown ends.
  logic [7:0] m_front [LB];
  logic [7:0] m_back  [LB];
  logic [7:0] m_pend  [LB];
  bit         m_front_valid, m_back_done;
  int         m_cnt, m_rd;
  int         e_ad, e_data;
  bit         e_valid, e_ready, e_late;
  bit         mon_en = 1'b0;

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      m_front_valid = 0; m_back_done = 0; m_cnt = 0; m_rd = 0;
      e_ad = 0; e_data = 0; e_valid = 0; e_ready = 0; e_late = 0;
    end else begin
      int base;
      bit ok;
      e_late  = line_start && (m_cnt > 0);
      e_ready = 0;
      if (line_start) begin
        if (m_back_done) begin
          m_front       = m_back;
          m_front_valid = 1;
        end
        for (int k = 0; k < LB; k++) m_pend[k] = mem[(int'(line_addr) + k) & MASK];
        m_cnt       = LB + 1;
        m_back_done = 0;
        e_ad        = int'(line_addr);
        base        = 0;
      end else begin
        base = m_rd;
        if (m_cnt > 0) begin
          if (m_cnt >= 3) e_ad = (e_ad + 1) & MASK;
          m_cnt--;
          if (m_cnt == 0) begin
            m_back      = m_pend;
            m_back_done = 1;
            e_ready     = 1;
          end
        end
      end
      ok      = px_req && m_front_valid && (base < LB);
      e_valid = ok;
      e_data  = ok ? int'(m_front[base]) : 0;
      m_rd    = ok ? base + 1 : base;
    end
  end

  always @(negedge clk_sys) begin
    if (mon_en) begin
      check("mon_ram_ad_b",   32'(ram_ad_b),   32'(e_ad));
      check("mon_busy",       32'(busy),       32'(m_cnt > 0));
      check("mon_line_ready", 32'(line_ready), 32'(e_ready));
      check("mon_late",       32'(late),       32'(e_late));
      check("mon_px_valid",   32'(px_valid),   32'(e_valid));
      check("mon_px_data",    32'(px_data),    32'(e_data));
      check("mon_ram_we_b",   32'(ram_we_b),   32'd0);
      check("mon_ram_d_b",    32'(ram_d_b),    32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  // Pulse line_start and follow the fetch until line_ready (bounded).
  task automatic do_line(input int base, output int rdy, output int bsy,
                         output int ad1, output int ad17, output int ad32);
    line_addr  = ADDR_W'(base);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    rdy = -1; bsy = 0; ad1 = -1; ad17 = -1; ad32 = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 1)  ad1  = int'(ram_ad_b);
      if (c == 17) ad17 = int'(ram_ad_b);
      if (c == 32) ad32 = int'(ram_ad_b);
      if (busy) bsy++;
      if (line_ready) begin
        rdy = c;
        break;
      end
      step();
    end
  endtask

  // Swap the just-filled bank to the front and read 33 bytes back to back.
  task automatic read_line(output int b0, output int b31, output int nvalid, output int last_valid);
    line_addr  = '0;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    px_req     = 1'b1;
    nvalid = 0; b0 = -1; b31 = -1; last_valid = -1;
    for (int i = 0; i < LB + 1; i++) begin
      step();
      if (px_valid) nvalid++;
      if (i == 0)  b0  = int'(px_data);
      if (i == 31) b31 = int'(px_data);
      if (i == 32) last_valid = int'(px_valid);
    end
    px_req = 1'b0;
  endtask

  typedef struct {
    int base;
    int ad_first;
    int ad_mid;
    int ad_last;
    int b0;
    int b31;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rdy, bsy, ad1, ad17, ad32, b0, b31, nv, lv, cnt;

    vecs[0] = '{base: 'h0100, ad_first: 'h0100, ad_mid: 'h0110, ad_last: 'h011F, b0: 'h00, b31: 'h1F};
    vecs[1] = '{base: 'h3FF0, ad_first: 'h3FF0, ad_mid: 'h0000, ad_last: 'h000F, b0: 'hF0, b31: 'h0F};
    vecs[2] = '{base: 'h1234, ad_first: 'h1234, ad_mid: 'h1244, ad_last: 'h1253, b0: 'h34, b31: 'h53};
    vecs[3] = '{base: 'h3FFF, ad_first: 'h3FFF, ad_mid: 'h000F, ad_last: 'h001E, b0: 'hFF, b31: 'h1E};

    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'(a);

    reset = 1'b1; line_start = 1'b0; line_addr = '0; px_req = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("reset_ram_ad_b",   32'(ram_ad_b),   0);
    check("reset_busy",       32'(busy),       0);
    check("reset_line_ready", 32'(line_ready), 0);
    check("reset_late",       32'(late),       0);
    check("reset_px_valid",   32'(px_valid),   0);
    check("reset_px_data",    32'(px_data),    0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // px_req before any swap: no valid bank to read from.
    px_req = 1'b1;
    step();
    px_req = 1'b0;
    check("early_req_valid", 32'(px_valid), 0);
    check("early_req_data",  32'(px_data),  0);

    // Table of line fetches, each followed by a swap and a full read.
    for (int v = 0; v < 4; v++) begin
      do_line(vecs[v].base, rdy, bsy, ad1, ad17, ad32);
      check($sformatf("v%0d_ready_cycle", v), 32'(rdy),  34);
      check($sformatf("v%0d_busy_cycles", v), 32'(bsy),  33);
      check($sformatf("v%0d_ad_first", v),    32'(ad1),  32'(vecs[v].ad_first));
      check($sformatf("v%0d_ad_mid", v),      32'(ad17), 32'(vecs[v].ad_mid));
      check($sformatf("v%0d_ad_last", v),     32'(ad32), 32'(vecs[v].ad_last));
      read_line(b0, b31, nv, lv);
      check($sformatf("v%0d_byte0", v),       32'(b0),   32'(vecs[v].b0));
      check($sformatf("v%0d_byte31", v),      32'(b31),  32'(vecs[v].b31));
      check($sformatf("v%0d_nvalid", v),      32'(nv),   32);
      check($sformatf("v%0d_33rd_valid", v),  32'(lv),   0);
    end

    // line_start together with px_req: the request reads the new front.
    do_line('h0245, rdy, bsy, ad1, ad17, ad32);
    check("same_cycle_fill_ready", 32'(rdy), 34);
    line_addr = 'h0377; line_start = 1'b1; px_req = 1'b1;
    step();
    line_start = 1'b0;
    check("same_cycle_valid", 32'(px_valid), 1);
    check("same_cycle_data",  32'(px_data),  'h45);
    step();
    px_req = 1'b0;
    check("same_cycle_next_data", 32'(px_data), 'h46);
    repeat (40) step();

    // Abort at cycle 10 of a fetch: late pulse, front kept, fetch restarts.
    line_addr = 'h0100; line_start = 1'b1;
    step();
    line_start = 1'b0;
    repeat (9) step();
    line_addr = 'h0388; line_start = 1'b1;
    step();
    line_start = 1'b0;
    check("abort_late_pulse", 32'(late),     1);
    check("abort_restart_ad", 32'(ram_ad_b), 'h0388);
    px_req = 1'b1;
    step();
    px_req = 1'b0;
    check("abort_late_cleared", 32'(late),     0);
    check("abort_front_valid",  32'(px_valid), 1);
    check("abort_front_kept",   32'(px_data),  'h77);
    rdy = -1;
    for (int c = 2; c <= 60; c++) begin
      if (line_ready) begin
        rdy = c;
        break;
      end
      step();
    end
    check("abort_ready_cycle", 32'(rdy), 34);
    read_line(b0, b31, nv, lv);
    check("abort_new_byte0",  32'(b0),  'h88);
    check("abort_new_byte31", 32'(b31), 'hA7);

    // Reset pulsed mid-fetch: outputs clear at once and no line_ready follows.
    line_addr = 'h0100; line_start = 1'b1;
    step();
    line_start = 1'b0;
    repeat (5) step();
    #1 reset = 1'b1;
    #1;
    check("midreset_busy",     32'(busy),       0);
    check("midreset_ram_ad_b", 32'(ram_ad_b),   0);
    check("midreset_px_valid", 32'(px_valid),   0);
    check("midreset_ready",    32'(line_ready), 0);
    #1 reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (line_ready) cnt++;
    end
    check("midreset_no_ready", 32'(cnt), 0);
    px_req = 1'b1;
    step();
    px_req = 1'b0;
    check("midreset_banks_invalid", 32'(px_valid), 0);
    do_line('h0400, rdy, bsy, ad1, ad17, ad32);
    check("midreset_next_ready", 32'(rdy), 34);
    check("midreset_next_ad",    32'(ad1), 'h0400);

    // Random phase against the reference model.
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      line_start = ($urandom_range(0, 39) == 0);
      line_addr  = ADDR_W'($urandom);
      px_req     = 1'($urandom_range(0, 1));
      step();
    end
    line_start = 1'b0;
    px_req     = 1'b0;
    repeat (40) step();

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
